// File: rtl/uart_mem_bridge.sv
// Command responder that turns UART byte frames into 32-bit bus reads/writes and replies.
// Frames: 'W' a3 a2 a1 a0 d3 d2 d1 d0 -> 'K'; 'R' a3 a2 a1 a0 -> 4 data bytes; other -> '?'.
module uart_mem_bridge #(
  parameter int GAP_CYCLES  = 500000,
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic [2:0]  dbgState
);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int BW = $clog2(BUS_TIMEOUT + 1);
  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] RSP_K = 8'h4B;
  localparam logic [7:0] RSP_Q = 8'h3F;
  localparam logic [7:0] RSP_E = 8'h45;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP, TXWAIT} state_t;

  state_t        state, stateNxt;
  logic          isWrite, isWriteNxt;
  logic [1:0]    byteCnt, byteCntNxt;
  logic [GW-1:0] gapCnt, gapCntNxt;
  logic [BW-1:0] busCnt, busCntNxt;
  logic [31:0]   respWord, respWordNxt;
  logic [2:0]    respLeft, respLeftNxt;
  logic          txFirst, txFirstNxt;
  logic [7:0]    txDataNxt;
  logic          txStartNxt, weNxt, reNxt;
  logic [31:0]   addrNxt, wdataNxt;

  assign busy     = (state != IDLE);
  assign dbgState = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      isWrite   <= 1'b0;
      byteCnt   <= '0;
      gapCnt    <= '0;
      busCnt    <= '0;
      respWord  <= '0;
      respLeft  <= '0;
      txFirst   <= 1'b0;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
    end else begin
      state     <= stateNxt;
      isWrite   <= isWriteNxt;
      byteCnt   <= byteCntNxt;
      gapCnt    <= gapCntNxt;
      busCnt    <= busCntNxt;
      respWord  <= respWordNxt;
      respLeft  <= respLeftNxt;
      txFirst   <= txFirstNxt;
      tx_data   <= txDataNxt;
      tx_start  <= txStartNxt;
      mem_addr  <= addrNxt;
      mem_wdata <= wdataNxt;
      mem_we    <= weNxt;
      mem_re    <= reNxt;
    end
  end

  always_comb begin
    stateNxt    = state;
    isWriteNxt  = isWrite;
    byteCntNxt  = byteCnt;
    gapCntNxt   = gapCnt;
    busCntNxt   = busCnt;
    respWordNxt = respWord;
    respLeftNxt = respLeft;
    txFirstNxt  = txFirst;
    txDataNxt   = tx_data;
    txStartNxt  = 1'b0;
    addrNxt     = mem_addr;
    wdataNxt    = mem_wdata;
    weNxt       = mem_we;
    reNxt       = mem_re;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_W || rx_data == CMD_R) begin
            isWriteNxt = (rx_data == CMD_W);
            byteCntNxt = '0;
            gapCntNxt  = '0;
            stateNxt   = ADDR;
          end else begin
            respWordNxt = {RSP_Q, 24'h0};
            respLeftNxt = 3'd1;
            stateNxt    = RESP;
          end
        end
      end
      ADDR, DATA: begin
        // A byte in the same cycle as gap expiry is accepted and restarts the gap count.
        if (rx_valid) begin
          if (state == ADDR) addrNxt  = {mem_addr[23:0], rx_data};
          else               wdataNxt = {mem_wdata[23:0], rx_data};
          byteCntNxt = byteCnt + 2'd1;
          gapCntNxt  = '0;
          if (byteCnt == 2'd3) begin
            busCntNxt = '0;
            if (state == ADDR && isWrite) stateNxt = DATA;
            else                          stateNxt = BUS;
          end
        end else if (gapCnt == GW'(GAP_CYCLES - 1)) begin
          gapCntNxt = '0;
          stateNxt  = IDLE;
        end else begin
          gapCntNxt = gapCnt + GW'(1);
        end
      end
      BUS: begin
        if (!(mem_we || mem_re)) begin
          weNxt     = isWrite;
          reNxt     = !isWrite;
          busCntNxt = '0;
        end else if (mem_ready) begin
          weNxt    = 1'b0;
          reNxt    = 1'b0;
          stateNxt = RESP;
          if (isWrite) begin
            respWordNxt = {RSP_K, 24'h0};
            respLeftNxt = 3'd1;
          end else begin
            respWordNxt = mem_rdata;
            respLeftNxt = 3'd4;
          end
        end else if (busCnt == BW'(BUS_TIMEOUT - 1)) begin
          weNxt       = 1'b0;
          reNxt       = 1'b0;
          respWordNxt = {RSP_E, 24'h0};
          respLeftNxt = 3'd1;
          stateNxt    = RESP;
        end else begin
          busCntNxt = busCnt + BW'(1);
        end
      end
      RESP: begin
        if (!tx_busy) begin
          txDataNxt   = respWord[31:24];
          txStartNxt  = 1'b1;
          respWordNxt = {respWord[23:0], 8'h00};
          respLeftNxt = respLeft - 3'd1;
          txFirstNxt  = 1'b1;
          stateNxt    = TXWAIT;
        end
      end
      TXWAIT: begin
        // The start cycle itself is skipped: tx_busy only rises one cycle later.
        if (txFirst) begin
          txFirstNxt = 1'b0;
        end else if (!tx_busy) begin
          stateNxt = (respLeft == 3'd0) ? IDLE : RESP;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_mem_bridge.sv
// Directed bench for uart_mem_bridge: frame-level reply/bus model plus per-cycle monitor.
module tb_uart_mem_bridge;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_we, mem_re;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        busy;
  logic [2:0]  dbgState;

  uart_mem_bridge #(.GAP_CYCLES(20), .BUS_TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy), .dbgState(dbgState)
  );

  always #5 clk = ~clk;

  int passCnt = 0;
  int totalCnt = 0;
  logic [7:0]  exp_q[$];
  logic [64:0] bus_q[$];

  int memLat = 3;
  logic [31:0] rdVal = '0;
  int txCount = 0;
  int strobeRises = 0;
  int lastStrobeLen = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Transmitter: busy rises the cycle after tx_start and stays high 4 cycles.
  initial begin
    int busyCnt = 0;
    bit pend = 0;
    forever begin
      @(posedge clk); #1;
      if (busyCnt > 0) begin
        busyCnt--;
        if (busyCnt == 0) tx_busy = 1'b0;
      end
      if (pend) begin
        tx_busy = 1'b1;
        busyCnt = 4;
        pend = 0;
      end
      if (tx_start) pend = 1;
    end
  end

  // Memory: mem_ready for one cycle memLat cycles after the strobe appears; memLat<0 never.
  initial begin
    int strobeCyc = 0;
    forever begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      if (mem_we || mem_re) begin
        if (memLat >= 0 && strobeCyc == memLat) begin
          mem_ready = 1'b1;
          mem_rdata = rdVal;
        end
        strobeCyc++;
      end else begin
        strobeCyc = 0;
      end
    end
  end

  // Monitor: checks tx bytes, bus transactions, latencies and tx_data stability.
  initial begin
    int cyc = 0;
    int lastRxCyc = 0;
    int readyCyc = 0;
    bit readyPend = 0;
    int strobeLen = 0;
    logic prevStart = 0, prevStrobe = 0, prevTxBusy = 0;
    logic [7:0] txHeld = '0;
    bit stableBad = 0, skipStable = 0;
    logic [64:0] op;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        skipStable = 1;
        readyPend = 0;
        strobeLen = 0;
      end else begin
        if (rx_valid) lastRxCyc = cyc;
        if (mem_ready) begin readyCyc = cyc; readyPend = 1; end
        if (tx_start && !prevStart) begin
          txCount++;
          check("tx_start_while_busy", {63'b0, tx_busy}, 64'd0);
          if (exp_q.size() == 0) begin
            check("unexpected_tx_start", {56'b0, tx_data}, 64'hFFFF);
          end else begin
            check("tx_byte", {56'b0, tx_data}, {56'b0, exp_q.pop_front()});
          end
          if (readyPend) begin
            check("ready_to_tx_latency", {63'b0, (cyc - readyCyc) <= 2}, 64'd1);
            readyPend = 0;
          end
          txHeld = tx_data;
          stableBad = 0;
          skipStable = 0;
        end
        if (tx_busy && tx_data !== txHeld) stableBad = 1;
        if (prevTxBusy && !tx_busy && !skipStable)
          check("tx_data_stable", {63'b0, stableBad}, 64'd0);
        if ((mem_we || mem_re) && !prevStrobe) begin
          strobeRises++;
          check("byte_to_strobe_latency", 64'(cyc - lastRxCyc), 64'd2);
          if (bus_q.size() == 0) begin
            check("unexpected_strobe", {62'b0, mem_we, mem_re}, 64'd0);
          end else begin
            op = bus_q.pop_front();
            check("bus_we_re", {62'b0, mem_we, mem_re}, {62'b0, op[64], !op[64]});
            check("bus_addr", {32'b0, mem_addr}, {32'b0, op[63:32]});
            if (op[64]) check("bus_wdata", {32'b0, mem_wdata}, {32'b0, op[31:0]});
          end
        end
        if (mem_we || mem_re) strobeLen++;
        else if (prevStrobe) begin lastStrobeLen = strobeLen; strobeLen = 0; end
      end
      prevStart = tx_start;
      prevStrobe = mem_we || mem_re;
      prevTxBusy = tx_busy;
    end
  end

  task automatic sendByte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  // Frame-level model: expected bus op and reply bytes follow from cmd and memory behaviour.
  task automatic frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data);
    if (cmd == 8'h57 || cmd == 8'h52) begin
      bus_q.push_back({cmd == 8'h57, addr, data});
      if (memLat < 0) exp_q.push_back(8'h45);
      else if (cmd == 8'h57) exp_q.push_back(8'h4B);
      else for (int i = 3; i >= 0; i--) exp_q.push_back(rdVal[i*8 +: 8]);
    end else begin
      exp_q.push_back(8'h3F);
    end
    sendByte(cmd);
    if (cmd == 8'h57 || cmd == 8'h52) begin
      for (int i = 3; i >= 0; i--) sendByte(addr[i*8 +: 8]);
      if (cmd == 8'h57) for (int i = 3; i >= 0; i--) sendByte(data[i*8 +: 8]);
    end
  endtask

  task automatic waitIdle(input string nm, input int budget);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(nm, {63'b0, busy}, 64'd0);
  endtask

  initial begin
    int baseTx, baseStr, n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {60'b0, tx_start, mem_we, mem_re, busy}, 64'd0);
    check("reset_data", {24'b0, tx_data, mem_addr}, 64'd0);
    check("reset_wdata", {32'b0, mem_wdata}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: write
    baseTx = txCount; baseStr = strobeRises; memLat = 3;
    frame(8'h57, 32'h0000_1000, 32'hDEAD_BEEF);
    waitIdle("t1_idle", 200);
    check("t1_tx_count", 64'(txCount - baseTx), 64'd1);
    check("t1_strobe_count", 64'(strobeRises - baseStr), 64'd1);
    check("t1_strobe_len", 64'(lastStrobeLen), 64'd4);
    check("t1_reply_drained", 64'(exp_q.size()), 64'd0);

    // 2: read
    baseTx = txCount; baseStr = strobeRises; rdVal = 32'h1234_5678;
    frame(8'h52, 32'h0000_1000, 32'h0);
    waitIdle("t2_idle", 300);
    check("t2_tx_count", 64'(txCount - baseTx), 64'd4);
    check("t2_strobe_count", 64'(strobeRises - baseStr), 64'd1);
    check("t2_reply_drained", 64'(exp_q.size()), 64'd0);

    // 3: unknown command
    baseTx = txCount; baseStr = strobeRises;
    frame(8'h41, 32'h0, 32'h0);
    waitIdle("t3_idle", 100);
    check("t3_tx_count", 64'(txCount - baseTx), 64'd1);
    check("t3_no_strobe", 64'(strobeRises - baseStr), 64'd0);

    // 4: partial frame abandoned by rx gap, then a good write
    baseTx = txCount; baseStr = strobeRises;
    sendByte(8'h52); sendByte(8'h00); sendByte(8'h00);
    repeat (10) @(negedge clk);
    check("t4_busy_mid_gap", {63'b0, busy}, 64'd1);
    repeat (20) @(negedge clk);
    check("t4_gap_idle", {63'b0, busy}, 64'd0);
    check("t4_no_tx", 64'(txCount - baseTx), 64'd0);
    check("t4_no_strobe", 64'(strobeRises - baseStr), 64'd0);
    frame(8'h57, 32'h0000_2000, 32'hCAFE_0001);
    waitIdle("t4_write_idle", 200);
    check("t4_write_tx", 64'(txCount - baseTx), 64'd1);

    // 5: bus timeout
    baseTx = txCount; memLat = -1;
    frame(8'h57, 32'h0000_4000, 32'h0102_0304);
    waitIdle("t5_idle", 600);
    check("t5_strobe_len", 64'(lastStrobeLen), 64'd255);
    check("t5_tx_count", 64'(txCount - baseTx), 64'd1);

    // 6: reset in the middle of a read reply
    memLat = 1; rdVal = 32'hA5A5_A5A5; baseTx = txCount;
    frame(8'h52, 32'h0000_3000, 32'h0);
    n = 0;
    while (txCount < baseTx + 2 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("t6_two_bytes_sent", 64'(txCount - baseTx), 64'd2);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t6_reset_ctrl", {60'b0, tx_start, mem_we, mem_re, busy}, 64'd0);
    check("t6_reset_data", {24'b0, tx_data, mem_addr}, 64'd0);
    check("t6_reset_wdata", {32'b0, mem_wdata}, 64'd0);
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("t6_no_more_tx", 64'(txCount - baseTx), 64'd2);
    check("t6_idle", {63'b0, busy}, 64'd0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
